// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx: first-word-fall-through stream, sticky overrun.
// Define UART_RX_FIFO_LEVEL_EN to add the registered occupancy output level_o.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] rx_dout_i,
  input  logic              rx_done_tick_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              empty_o,
  output logic              full_o,
  output logic              overrun_o,
`ifdef UART_RX_FIFO_LEVEL_EN
  output logic [$clog2(DEPTH):0] level_o,
`endif
  input  logic              clr_overrun_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ovr_q, ovr_d;
  logic              empty, full;
  logic              push, pop, drop;

  // Extra pointer MSB separates full (MSBs differ) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = !empty && m_ready_i;
  assign push = rx_done_tick_i && (!full || pop);
  assign drop = rx_done_tick_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (clr_overrun_i) ovr_d = 1'b0;
    if (drop) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_dout_i;
    end
  end

  assign m_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid_o = !empty;
  assign empty_o   = empty;
  assign full_o    = full;
  assign overrun_o = ovr_q;

`ifdef UART_RX_FIFO_LEVEL_EN
  logic [PW-1:0] level_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) level_q <= '0;
    else         level_q <= wr_ptr_d - rd_ptr_d;
  end

  assign level_o = level_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus multi-cycle sequences.
// Honors UART_RX_FIFO_LEVEL_EN to check level_o.
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] rx_dout_i;
  logic       rx_done_tick_i;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       empty_o;
  logic       full_o;
  logic       overrun_o;
  logic       clr_overrun_i;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [4:0] level_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .rx_dout_i      (rx_dout_i),
    .rx_done_tick_i (rx_done_tick_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .overrun_o      (overrun_o),
`ifdef UART_RX_FIFO_LEVEL_EN
    .level_o        (level_o),
`endif
    .clr_overrun_i  (clr_overrun_i)
  );

  typedef struct {
    logic       tick;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_empty;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_dout_i      = d;
    rx_done_tick_i = 1'b1;
    step();
    rx_done_tick_i = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, 32'(m_valid_o), 32'd1);
    chk({name, "_data"}, 32'(m_data_o), 32'(exp));
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
  endtask

  initial begin
    // single byte, then backpressure with ready toggling 1010...
    vecs[0] = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    rstn_i         = 1'b0;
    rx_dout_i      = 8'h00;
    rx_done_tick_i = 1'b0;
    m_ready_i      = 1'b0;
    clr_overrun_i  = 1'b0;
    repeat (2) step();

    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data",  32'(m_data_o),  32'd0);
    chk("rst_empty", 32'(empty_o),   32'd1);
    chk("rst_full",  32'(full_o),    32'd0);
    chk("rst_ovr",   32'(overrun_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("rst_level", 32'(level_o), 32'd0);
`endif
    rstn_i = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      rx_dout_i      = vecs[i].din;
      rx_done_tick_i = vecs[i].tick;
      m_ready_i      = vecs[i].rdy;
      clr_overrun_i  = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(m_valid_o), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_data", i), 32'(m_data_o), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i), 32'(full_o), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun_o), 32'(vecs[i].e_ovr));
    end
    rx_done_tick_i = 1'b0;
    m_ready_i      = 1'b0;
    clr_overrun_i  = 1'b0;

    // fill 0x00..0x0F, ticks 10 cycles apart
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk($sformatf("fill%0d_full", i), 32'(full_o), 32'(i == 15));
      chk($sformatf("fill%0d_head", i), 32'(m_data_o), 32'h00);
      repeat (9) step();
    end
    chk("fill_empty", 32'(empty_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("fill_level", 32'(level_o), 32'd16);
`endif

    push(8'hEE);
    chk("ovr_set",  32'(overrun_o), 32'd1);
    chk("ovr_full", 32'(full_o),    32'd1);
    chk("ovr_head", 32'(m_data_o),  32'h00);

    clr_overrun_i = 1'b1;
    push(8'hEF);
    clr_overrun_i = 1'b0;
    chk("ovr_setwins", 32'(overrun_o), 32'd1);

    clr_overrun_i = 1'b1;
    step();
    clr_overrun_i = 1'b0;
    chk("ovr_clr", 32'(overrun_o), 32'd0);

    // full with simultaneous push and pop
    chk("pp_head_before", 32'(m_data_o), 32'h00);
    rx_dout_i      = 8'h55;
    rx_done_tick_i = 1'b1;
    m_ready_i      = 1'b1;
    step();
    rx_done_tick_i = 1'b0;
    m_ready_i      = 1'b0;
    chk("pp_full", 32'(full_o),    32'd1);
    chk("pp_ovr",  32'(overrun_o), 32'd0);
    chk("pp_head", 32'(m_data_o),  32'h01);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("pp_level", 32'(level_o), 32'd16);
`endif

    for (int i = 0; i < 16; i++)
      pop_chk($sformatf("drain%0d", i), (i < 15) ? 8'(i + 1) : 8'h55);
    chk("drain_empty", 32'(empty_o),   32'd1);
    chk("drain_valid", 32'(m_valid_o), 32'd0);

    // stray ready on an empty FIFO must not move the pointers
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;

    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 8; i++)
      pop_chk($sformatf("wrap%0d", i), 8'(8'h10 + i));
    chk("wrap_empty", 32'(empty_o), 32'd1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk("pre_rst_valid", 32'(m_valid_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid_o), 32'd0);
    chk("arst_empty", 32'(empty_o),   32'd1);
    chk("arst_ovr",   32'(overrun_o), 32'd0);
    chk("arst_data",  32'(m_data_o),  32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("arst_level", 32'(level_o), 32'd0);
`endif
    #2 rstn_i = 1'b1;
    step();
    push(8'h3C);
    chk("post_rst_valid", 32'(m_valid_o), 32'd1);
    chk("post_rst_data",  32'(m_data_o),  32'h3C);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("post_rst_level", 32'(level_o), 32'd1);
`endif
    pop_chk("post_rst_pop", 8'h3C);
    chk("post_rst_empty", 32'(empty_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
